// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: op sizes, FSM states and byte masks.
package wb_pkg;

  localparam logic [1:0] OPSZ_8  = 2'b00;
  localparam logic [1:0] OPSZ_16 = 2'b01;
  localparam logic [1:0] OPSZ_32 = 2'b10;
  localparam logic [1:0] OPSZ_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM0 = 2'd1,
    ST_MEM1 = 2'd2
  } wb_state_t;

  localparam logic [7:0] MASK_8  = 8'h01;
  localparam logic [7:0] MASK_16 = 8'h03;
  localparam logic [7:0] MASK_32 = 8'h0F;
  localparam logic [7:0] MASK_64 = 8'hFF;

  localparam logic [3:0] BE_LO   = 4'b0001;
  localparam logic [3:0] BE_HI   = 4'b0010;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [7:0] size_mask(input logic [1:0] opsize);
    case (opsize)
      OPSZ_8:  size_mask = MASK_8;
      OPSZ_16: size_mask = MASK_16;
      OPSZ_32: size_mask = MASK_32;
      default: size_mask = MASK_64;
    endcase
  endfunction

endpackage

// File: rtl/wb_store_align.sv
// Splits a store into one or two word-aligned 32-bit beats with byte enables.
module wb_store_align
  import wb_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  opsize,
  input  logic [63:0] result,
  output logic [31:0] beat0_addr,
  output logic [31:0] beat0_data,
  output logic [3:0]  beat0_be,
  output logic [31:0] beat1_addr,
  output logic [31:0] beat1_data,
  output logic [3:0]  beat1_be,
  output logic        split
);

  logic [1:0]  k;
  logic [5:0]  shamt;
  logic [7:0]  lanes;
  logic [63:0] window;

  // 64b stores are assumed word aligned, so the byte offset is ignored for them
  assign k      = (opsize == OPSZ_64) ? 2'b00 : addr[1:0];
  assign shamt  = {1'b0, k, 3'b000};
  assign lanes  = size_mask(opsize) << k;
  assign window = result << shamt;

  assign beat0_addr = {addr[31:2], 2'b00};
  assign beat1_addr = {addr[31:2] + 30'd1, 2'b00};
  assign beat0_data = window[31:0];
  assign beat1_data = window[63:32];
  assign beat0_be   = lanes[3:0];
  assign beat1_be   = lanes[7:4];
  assign split      = |lanes[7:4];

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: retires register results to GPR/MMX files and memory results as store beats.
//
// state   | meaning
// ST_IDLE | ready for a new op; register ops retire from here
// ST_MEM0 | first store beat on mem_req, waiting for mem_ack
// ST_MEM1 | second (high word) store beat, waiting for mem_ack
module writeback_top
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_dest_address,
  input  logic [31:0] wb_dest_reg,
  input  logic [63:0] wb_result,
  input  logic [1:0]  wb_opsize,
  input  logic        wb_mem_or_reg,
  input  logic        wb_branch_taken,
  input  logic        wb_to_sys_controller,
  input  logic [31:0] wb_pc,
  output logic        rf_we,
  output logic [2:0]  rf_idx,
  output logic [31:0] rf_data,
  output logic [3:0]  rf_be,
  output logic        mm_we,
  output logic [2:0]  mm_idx,
  output logic [63:0] mm_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic        sys_valid,
  output logic        sys_branch_taken
);

  wb_state_t   state;
  logic [2:0]  idx;
  logic        unused_dest_bits;
  logic [2:0]  gpr_idx;
  logic [3:0]  gpr_be;
  logic [31:0] gpr_data;

  logic [31:0] b0_addr, b0_data, b1_addr, b1_data;
  logic [3:0]  b0_be, b1_be;
  logic        split;

  logic [31:0] b1_addr_q, b1_data_q, pc_q;
  logic [3:0]  b1_be_q;
  logic        split_q, sys_q, br_q;

  assign idx              = wb_dest_reg[2:0];
  assign unused_dest_bits = ^wb_dest_reg[31:3];
  assign wb_ready         = (state == ST_IDLE);

  wb_store_align u_align (
    .addr       (wb_dest_address),
    .opsize     (wb_opsize),
    .result     (wb_result),
    .beat0_addr (b0_addr),
    .beat0_data (b0_data),
    .beat0_be   (b0_be),
    .beat1_addr (b1_addr),
    .beat1_data (b1_data),
    .beat1_be   (b1_be),
    .split      (split)
  );

  // Byte registers AH..BH (idx 4..7) live in byte 1 of registers 0..3
  always_comb begin
    gpr_idx  = idx;
    gpr_be   = BE_WORD;
    gpr_data = wb_result[31:0];
    case (wb_opsize)
      OPSZ_16: begin
        gpr_be   = BE_HALF;
        gpr_data = {16'h0000, wb_result[15:0]};
      end
      OPSZ_8: begin
        if (idx[2]) begin
          gpr_idx  = {1'b0, idx[1:0]};
          gpr_be   = BE_HI;
          gpr_data = {16'h0000, wb_result[7:0], 8'h00};
        end else begin
          gpr_be   = BE_LO;
          gpr_data = {24'h000000, wb_result[7:0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      rf_we            <= 1'b0;
      rf_idx           <= 3'd0;
      rf_data          <= 32'd0;
      rf_be            <= 4'd0;
      mm_we            <= 1'b0;
      mm_idx           <= 3'd0;
      mm_data          <= 64'd0;
      mem_req          <= 1'b0;
      mem_addr         <= 32'd0;
      mem_wdata        <= 32'd0;
      mem_be           <= 4'd0;
      retire_valid     <= 1'b0;
      retire_pc        <= 32'd0;
      sys_valid        <= 1'b0;
      sys_branch_taken <= 1'b0;
      b1_addr_q        <= 32'd0;
      b1_data_q        <= 32'd0;
      b1_be_q          <= 4'd0;
      split_q          <= 1'b0;
      pc_q             <= 32'd0;
      sys_q            <= 1'b0;
      br_q             <= 1'b0;
    end else begin
      rf_we            <= 1'b0;
      mm_we            <= 1'b0;
      retire_valid     <= 1'b0;
      sys_valid        <= 1'b0;
      sys_branch_taken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_valid) begin
            pc_q  <= wb_pc;
            sys_q <= wb_to_sys_controller;
            br_q  <= wb_branch_taken;
            if (wb_mem_or_reg) begin
              state     <= ST_MEM0;
              mem_req   <= 1'b1;
              mem_addr  <= b0_addr;
              mem_wdata <= b0_data;
              mem_be    <= b0_be;
              b1_addr_q <= b1_addr;
              b1_data_q <= b1_data;
              b1_be_q   <= b1_be;
              split_q   <= split;
            end else begin
              retire_valid     <= 1'b1;
              retire_pc        <= wb_pc;
              sys_valid        <= wb_to_sys_controller;
              sys_branch_taken <= wb_to_sys_controller & wb_branch_taken;
              if (wb_opsize == OPSZ_64) begin
                mm_we   <= 1'b1;
                mm_idx  <= idx;
                mm_data <= wb_result;
              end else begin
                rf_we   <= 1'b1;
                rf_idx  <= gpr_idx;
                rf_be   <= gpr_be;
                rf_data <= gpr_data;
              end
            end
          end
        end
        ST_MEM0, ST_MEM1: begin
          if (mem_ack) begin
            if (state == ST_MEM0 && split_q) begin
              state     <= ST_MEM1;
              mem_addr  <= b1_addr_q;
              mem_wdata <= b1_data_q;
              mem_be    <= b1_be_q;
            end else begin
              state            <= ST_IDLE;
              mem_req          <= 1'b0;
              mem_be           <= 4'd0;
              retire_valid     <= 1'b1;
              retire_pc        <= pc_q;
              sys_valid        <= sys_q;
              sys_branch_taken <= sys_q & br_q;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_top.sv
// Self-checking bench for writeback_top: directed cases plus randomized ops against a byte-level model.
module tb_writeback_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_dest_address;
  logic [31:0] wb_dest_reg;
  logic [63:0] wb_result;
  logic [1:0]  wb_opsize;
  logic        wb_mem_or_reg;
  logic        wb_branch_taken;
  logic        wb_to_sys_controller;
  logic [31:0] wb_pc;
  logic        rf_we;
  logic [2:0]  rf_idx;
  logic [31:0] rf_data;
  logic [3:0]  rf_be;
  logic        mm_we;
  logic [2:0]  mm_idx;
  logic [63:0] mm_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        sys_valid;
  logic        sys_branch_taken;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_top dut (
    .clk                  (clk),
    .reset                (reset),
    .wb_valid             (wb_valid),
    .wb_ready             (wb_ready),
    .wb_dest_address      (wb_dest_address),
    .wb_dest_reg          (wb_dest_reg),
    .wb_result            (wb_result),
    .wb_opsize            (wb_opsize),
    .wb_mem_or_reg        (wb_mem_or_reg),
    .wb_branch_taken      (wb_branch_taken),
    .wb_to_sys_controller (wb_to_sys_controller),
    .wb_pc                (wb_pc),
    .rf_we                (rf_we),
    .rf_idx               (rf_idx),
    .rf_data              (rf_data),
    .rf_be                (rf_be),
    .mm_we                (mm_we),
    .mm_idx               (mm_idx),
    .mm_data              (mm_data),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .mem_ack              (mem_ack),
    .retire_valid         (retire_valid),
    .retire_pc            (retire_pc),
    .sys_valid            (sys_valid),
    .sys_branch_taken     (sys_branch_taken)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register-file model straight from the mapping rules
  task automatic ref_gpr(input logic [1:0] sz, input int idx, input logic [63:0] res,
                         output int eidx, output logic [3:0] ebe, output logic [31:0] edata);
    eidx = idx;
    if (sz == 2'd2) begin ebe = 4'hF; edata = res[31:0]; end
    else if (sz == 2'd1) begin ebe = 4'h3; edata = res[31:0] & 32'h0000FFFF; end
    else if (idx < 4) begin ebe = 4'h1; edata = res[31:0] & 32'h000000FF; end
    else begin eidx = idx - 4; ebe = 4'h2; edata = (res[31:0] & 32'h000000FF) * 256; end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic reg_op(input logic [1:0] sz, input int idx, input logic [63:0] res,
                        input bit sys, input bit br, input logic [31:0] pc);
    int eidx;
    logic [3:0] ebe;
    logic [31:0] edata;
    wb_valid = 1'b1;
    wb_mem_or_reg = 1'b0;
    wb_opsize = sz;
    wb_dest_reg = ($urandom() & 32'hFFFF_FFF8) | idx;
    wb_dest_address = $urandom();
    wb_result = res;
    wb_to_sys_controller = sys;
    wb_branch_taken = br;
    wb_pc = pc;
    step();
    chk("reg_retire", retire_valid, 1);
    chk("reg_retire_pc", retire_pc, pc);
    chk("reg_sys_valid", sys_valid, sys);
    chk("reg_sys_br", sys_branch_taken, sys & br);
    chk("reg_ready", wb_ready, 1);
    chk("reg_mem_req", mem_req, 0);
    if (sz == 2'd3) begin
      chk("mm_we", mm_we, 1);
      chk("mm_rf_we", rf_we, 0);
      chk("mm_idx", mm_idx, idx);
      chk("mm_data", mm_data, res);
    end else begin
      ref_gpr(sz, idx, res, eidx, ebe, edata);
      chk("rf_we", rf_we, 1);
      chk("rf_mm_we", mm_we, 0);
      chk("rf_idx", rf_idx, eidx);
      chk("rf_be", rf_be, ebe);
      chk("rf_data", rf_data, edata);
    end
  endtask

  // Store model: place each result byte at its byte address, then group by word
  task automatic mem_op(input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] res,
                        input logic [31:0] pc, input int dly);
    logic [3:0]  mbe  [2];
    logic [31:0] mdat [2];
    logic [31:0] base, a;
    int nbeats, w, lane;
    base = (sz == 2'd3) ? (addr & 32'hFFFF_FFFC) : addr;
    mbe[0] = 0; mbe[1] = 0; mdat[0] = 0; mdat[1] = 0;
    for (int i = 0; i < (1 << sz); i++) begin
      a = base + i;
      w = int'((a >> 2) - (base >> 2));
      lane = int'(a[1:0]);
      mbe[w][lane] = 1'b1;
      mdat[w][8*lane +: 8] = res[8*i +: 8];
    end
    nbeats = (mbe[1] != 0) ? 2 : 1;
    wb_valid = 1'b1;
    wb_mem_or_reg = 1'b1;
    wb_opsize = sz;
    wb_dest_reg = $urandom();
    wb_dest_address = addr;
    wb_result = res;
    wb_to_sys_controller = 1'b0;
    wb_branch_taken = 1'b0;
    wb_pc = pc;
    step();
    wb_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      for (int d = 0; d <= dly; d++) begin
        chk("st_req", mem_req, 1);
        chk("st_addr", mem_addr, ((base >> 2) + b) << 2);
        chk("st_be", mem_be, mbe[b]);
        chk("st_data", mem_wdata & be_mask(mbe[b]), mdat[b]);
        chk("st_ready", wb_ready, 0);
        chk("st_no_retire", retire_valid, 0);
        if (d == dly) mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
      end
    end
    chk("st_retire", retire_valid, 1);
    chk("st_retire_pc", retire_pc, pc);
    chk("st_req_done", mem_req, 0);
    chk("st_ready_done", wb_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 1'b0;
    wb_dest_address = 0;
    wb_dest_reg = 0;
    wb_result = 0;
    wb_opsize = 0;
    wb_mem_or_reg = 0;
    wb_branch_taken = 0;
    wb_to_sys_controller = 0;
    wb_pc = 0;
    mem_ack = 0;
    step();
    step();
    chk("rst_ready", wb_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mm_we", mm_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_sys", sys_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++)
      reg_op(2'd2, i, {$urandom(), $urandom()}, 1'b0, 1'b0, 32'h100 + 4 * i);
    wb_valid = 1'b0;
    step();
    chk("burst_end_we", rf_we, 0);
    chk("burst_end_retire", retire_valid, 0);

    reg_op(2'd0, 5, 64'hAB, 1'b0, 1'b0, 32'h200);
    chk("ch_byte", rf_data[15:8], 8'hAB);

    reg_op(2'd1, 3, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 32'h300);
    reg_op(2'd2, 6, 64'h5555_AAAA, 1'b1, 1'b0, 32'h304);
    wb_valid = 1'b0;

    mem_op(32'h1002, 2'd2, 64'hDEADBEEF, 32'h400, 0);
    mem_op(32'h2000, 2'd3, 64'h0123_4567_89AB_CDEF, 32'h404, 3);

    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_retire", retire_valid, 0);

    wb_valid = 1'b1;
    wb_mem_or_reg = 1'b1;
    wb_opsize = 2'd3;
    wb_dest_address = 32'h3000;
    wb_result = 64'hCAFE_F00D_1111_2222;
    wb_pc = 32'h500;
    step();
    wb_valid = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("mem1_req", mem_req, 1);
    chk("mem1_addr", mem_addr, 32'h3004);
    reset = 1'b1;
    step();
    chk("midrst_req", mem_req, 0);
    chk("midrst_ready", wb_ready, 1);
    chk("midrst_retire", retire_valid, 0);
    reset = 1'b0;
    step();
    chk("postrst_retire", retire_valid, 0);
    chk("postrst_req", mem_req, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      logic [63:0] rs;
      sz = 2'($urandom_range(0, 3));
      rs = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) begin
        ad = $urandom();
        if (sz == 2'd3) ad[1:0] = 2'b00;
        mem_op(ad, sz, rs, $urandom(), int'($urandom_range(0, 2)));
      end else begin
        reg_op(sz, int'($urandom_range(0, 7)), rs, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom());
      end
    end
    wb_valid = 1'b0;
    step();
    chk("final_retire", retire_valid, 0);
    chk("final_ready", wb_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
